// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program counter and fetch stage in front of a
// byte-addressed, combinational instruction memory. It fetches big-endian
// 16-bit words and hands them to decode through a registered IF/ID latch.
// It handles stall hold, branch redirect with flush, and halt detection.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_BYTES   = 256,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc_out,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  // MEM_BYTES is a power of two, so modulo reduces to masking.
  localparam logic [15:0] PC_MASK = 16'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_r,       state_s;
  logic [15:0] pc_r,          pc_s;
  logic [15:0] if_instr_r,    if_instr_s;
  logic [15:0] if_pc_r,       if_pc_s;
  logic        if_valid_r,    if_valid_s;
  logic        halted_r,      halted_s;
  logic [15:0] fetch_count_r, fetch_count_s;

  // Reduce an address into the instruction memory range.
  function automatic logic [15:0] wrap_pc(input logic [15:0] addr);
    return addr & PC_MASK;
  endfunction

  // Increment the issue counter, but stop at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Compute next state and next datapath values. Each value holds unless an action below changes it.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    if_instr_s    = if_instr_r;
    if_pc_s       = if_pc_r;
    if_valid_s    = if_valid_r;
    halted_s      = halted_r;
    fetch_count_s = fetch_count_r;

    case (state_r)
      ST_START: begin
        // One bubble after reset; redirect and backpressure are not observed yet.
        if_valid_s = 1'b0;
        state_s    = ST_FETCH;
      end

      ST_FETCH: begin
        if (branch_taken) begin
          // A redirect flushes the latch, even when decode is stalled.
          pc_s       = wrap_pc(branch_target & 16'hFFFE);
          if_valid_s = 1'b0;
          if_instr_s = 16'h0000;
        end else if (stall) begin
          pc_s       = pc_r;
          if_valid_s = if_valid_r;
        end else begin
          if_instr_s    = instr_in;
          if_pc_s       = pc_r;
          if_valid_s    = 1'b1;
          fetch_count_s = sat_inc(fetch_count_r);
          if (instr_in[15:12] == HALT_OPCODE) begin
            // Freeze on the halt word; it stays the last issued instruction.
            pc_s    = pc_r;
            state_s = ST_HALT;
          end else begin
            pc_s    = wrap_pc(pc_r + 16'd2);
            state_s = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        // Only reset leaves this state. The halt word retires on its first unstalled edge.
        halted_s = 1'b1;
        if (!stall) begin
          if_valid_s = 1'b0;
        end else begin
          if_valid_s = if_valid_r;
        end
      end

      default: begin
        // Recover from an illegal encoding by restarting the fetch sequence.
        state_s    = ST_START;
        if_valid_s = 1'b0;
      end
    endcase
  end

  // Hold the FSM state and datapath registers; clear them asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_START;
      pc_r          <= RESET_PC;
      if_instr_r    <= 16'h0000;
      if_pc_r       <= 16'h0000;
      if_valid_r    <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 16'h0000;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      if_instr_r    <= if_instr_s;
      if_pc_r       <= if_pc_s;
      if_valid_r    <= if_valid_s;
      halted_r      <= halted_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign pc_out      = pc_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign if_valid    = if_valid_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus randomized stimulus against a
// cycle-level behavioural model of the fetch stage and a byte memory.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];

  int n_total = 0;
  int n_pass  = 0;

  // Model of the expected architectural state.
  int          m_pc;
  logic [15:0] m_instr;
  int          m_ipc;
  bit          m_valid;
  int          m_count;
  bit          m_bubble;
  bit          m_stopped;
  int          m_stop_edges;

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset        (rst_n),
    .pc_out       (pc_out),
    .instr_in     (instr_in),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational big-endian memory read (pc_out is always even)
  always_comb instr_in = {mem[pc_out[7:0]], mem[pc_out[7:0] | 8'h01]};

  function automatic logic [15:0] mem_word(input int a);
    return {mem[a], mem[a + 1]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 16'h0000; m_ipc = 0; m_valid = 1'b0; m_count = 0;
    m_bubble = 1'b1; m_stopped = 1'b0; m_stop_edges = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc_out"},      pc_out,      16'(m_pc));
    chk({where, ".if_valid"},    {15'd0, if_valid}, {15'd0, m_valid});
    chk({where, ".if_instr"},    if_instr,    m_instr);
    chk({where, ".if_pc"},       if_pc,       16'(m_ipc));
    chk({where, ".halted"},      {15'd0, halted},   {15'd0, m_stop_edges > 0});
    chk({where, ".fetch_count"}, fetch_count, 16'(m_count));
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, compare after the edge
  task automatic do_cycle(input bit st, input bit br, input logic [15:0] tgt);
    logic [15:0] w;
    stall = st; branch_taken = br; branch_target = tgt;
    if (m_bubble) begin
      m_bubble = 1'b0;
      m_valid  = 1'b0;
    end else if (m_stopped) begin
      m_stop_edges++;
      if (!st) m_valid = 1'b0;
    end else if (br) begin
      m_pc    = (int'(tgt) / 2 * 2) % 256;
      m_valid = 1'b0;
      m_instr = 16'h0000;
    end else if (!st) begin
      w       = mem_word(m_pc);
      m_instr = w;
      m_ipc   = m_pc;
      m_valid = 1'b1;
      if (m_count < 65535) m_count++;
      if (w[15:12] == 4'hF) m_stopped = 1'b1;
      else m_pc = (m_pc + 2) % 256;
    end
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 256; i += 2) if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h7;
    {mem[0], mem[1]} = 16'h3112;
    {mem[2], mem[3]} = 16'h3413;
    {mem[4], mem[5]} = 16'h0140;
    {mem[6], mem[7]} = 16'h0241;
    {mem[8], mem[9]} = 16'h1234;

    // Reset state
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // START bubble, then sequential fetch with a 3-cycle stall at if_pc=2
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("bubble_valid", {15'd0, if_valid}, 16'd0);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("first_instr", if_instr, 16'h3112);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("second_pc", if_pc, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 16'h0000);
      chk("stall_pc", pc_out, 16'h0004);
      chk("stall_instr", if_instr, 16'h3413);
    end
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("resume_instr", if_instr, 16'h0140);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("fourth_instr", if_instr, 16'h0241);
    chk("count4", fetch_count, 16'd4);

    // Branch wins over stall; odd target rounds down
    do_cycle(1'b1, 1'b1, 16'h0007);
    chk("br_pc", pc_out, 16'h0006);
    chk("br_flush", {15'd0, if_valid}, 16'd0);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("br_instr", if_instr, 16'h0241);

    // Target beyond memory reduced, then wrap from 0xFE to 0
    do_cycle(1'b0, 1'b1, 16'h01FE);
    chk("br_mod", pc_out, 16'h00FE);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", pc_out, 16'h0000);
    chk("wrap_ifpc", if_pc, 16'h00FE);

    // Randomized traffic (no halt words present in memory)
    for (int i = 0; i < 300; i++)
      do_cycle(($urandom % 4) == 0, ($urandom % 8) == 0, 16'($urandom));

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("rst_bubble", {15'd0, if_valid}, 16'd0);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("rst_first", if_instr, 16'h3112);

    // Halt word at address 8
    {mem[8], mem[9]} = 16'hF000;
    do_cycle(1'b0, 1'b1, 16'h0008);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("halt_instr", if_instr, 16'hF000);
    chk("halt_not_yet", {15'd0, halted}, 16'd0);
    do_cycle(1'b1, 1'b0, 16'h0000);
    chk("halted", {15'd0, halted}, 16'd1);
    chk("halt_valid_held", {15'd0, if_valid}, 16'd1);
    do_cycle(1'b0, 1'b0, 16'h0000);
    chk("halt_retired", {15'd0, if_valid}, 16'd0);
    do_cycle(1'b0, 1'b1, 16'h0040);
    chk("halt_ignores_br", pc_out, 16'h0008);
    for (int i = 0; i < 5; i++)
      do_cycle(($urandom % 2) == 0, ($urandom % 2) == 0, 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
